// File: rtl/lab3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lab3_pkg                                                   |
// | Description : Shared types and constants for the LAB3 pattern master:    |
// |               default symbol width, default buffer depth, FSM state      |
// |               encoding and an address-width helper.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lab3_pkg;

  localparam int LAB3_SYM_W  = 3;
  localparam int LAB3_DEPTH  = 16;
  localparam int LAB3_ADDR_W = $clog2(LAB3_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab3_sym_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lab3_sym_buf                                               |
// | Description : DEPTH x WIDTH symbol store, synchronous write and          |
// |               asynchronous (combinational) read. Contents are not reset. |
// | Ports       : clk                 write clock                            |
// |               i_we/i_waddr/i_wdata write port                            |
// |               i_raddr/o_rdata      combinational read port               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lab3_sym_buf
  import lab3_pkg::*;
#(
  parameter int DEPTH  = LAB3_DEPTH,
  parameter int WIDTH  = LAB3_SYM_W,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lab3_pattern_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lab3_pattern_master                                        |
// | Description : Replays a host-loaded frame of symbols on IN_VALID/INPUT,  |
// |               then captures the OUT_VALID/OUT response burst into a      |
// |               readable buffer. Sticky timeout/overflow status.           |
// | Ports       : CLK, RST (async, active-low)                               |
// |               clear/load_en/load_data/start : host control (IDLE only)   |
// |               IN_VALID/INPUT                : stimulus to LAB3           |
// |               OUT_VALID/OUT                 : response from LAB3         |
// |               busy/done/timeout/overflow    : status                     |
// |               tx_count/rx_count             : buffer fill levels         |
// |               rd_addr/rd_data               : RX buffer read port        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lab3_pattern_master
  import lab3_pkg::*;
#(
  parameter int DEPTH   = LAB3_DEPTH,
  parameter int TIMEOUT = 1000,
  parameter int SYM_W   = LAB3_SYM_W,
  localparam int ADDR_W  = addr_w(DEPTH),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              load_en,
  input  logic [SYM_W-1:0]  load_data,
  input  logic              start,
  output logic              IN_VALID,
  output logic [SYM_W-1:0]  INPUT,
  input  logic              OUT_VALID,
  input  logic [SYM_W-1:0]  OUT,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SYM_W-1:0]  rd_data
);

  // Timer only has to reach TIMEOUT-1 before the FSM leaves WAIT.
  localparam int TIMER_W = addr_w(TIMEOUT);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   send_idx_q, send_idx_d;
  logic [TIMER_W-1:0] timer_q,    timer_d;
  logic               in_valid_q, in_valid_d;
  logic [SYM_W-1:0]   sym_out_q,  sym_out_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               timeout_q,  timeout_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;

  logic               tx_we;
  logic [ADDR_W-1:0]  tx_raddr;
  logic [SYM_W-1:0]   tx_rdata;
  logic               rx_we;
  logic [ADDR_W-1:0]  rx_waddr;

  // In IDLE the TX buffer is pre-read at entry 0 so the first symbol can be
  // registered on the same edge that accepts start.
  assign tx_raddr = (state_q == ST_SEND) ? send_idx_q[ADDR_W-1:0] : '0;

  lab3_sym_buf #(.DEPTH(DEPTH), .WIDTH(SYM_W)) u_tx_buf (
    .clk     (CLK),
    .i_we    (tx_we),
    .i_waddr (tx_count_q[ADDR_W-1:0]),
    .i_wdata (load_data),
    .i_raddr (tx_raddr),
    .o_rdata (tx_rdata)
  );

  lab3_sym_buf #(.DEPTH(DEPTH), .WIDTH(SYM_W)) u_rx_buf (
    .clk     (CLK),
    .i_we    (rx_we),
    .i_waddr (rx_waddr),
    .i_wdata (OUT),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    send_idx_d = send_idx_q;
    timer_d    = timer_q;
    in_valid_d = in_valid_q;
    sym_out_d  = sym_out_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    tx_we      = 1'b0;
    rx_we      = 1'b0;
    rx_waddr   = '0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          tx_count_d = '0;
        end else if (load_en) begin
          if (tx_count_q != FULL_CNT) begin
            tx_we      = 1'b1;
            tx_count_d = tx_count_q + 1'b1;
          end
        end else if (start && (tx_count_q != '0)) begin
          rx_count_d = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          timer_d    = '0;
          in_valid_d = 1'b1;
          sym_out_d  = tx_rdata;
          send_idx_d = CNT_W'(1);
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (send_idx_q == tx_count_q) begin
          in_valid_d = 1'b0;
          sym_out_d  = '0;
          state_d    = ST_WAIT;
        end else begin
          sym_out_d  = tx_rdata;
          send_idx_d = send_idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A response on the expiry cycle is still captured.
        if (OUT_VALID) begin
          rx_we      = 1'b1;
          rx_count_d = CNT_W'(1);
          state_d    = ST_RECV;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RECV: begin
        if (OUT_VALID) begin
          if (rx_count_q != FULL_CNT) begin
            rx_we      = 1'b1;
            rx_waddr   = rx_count_q[ADDR_W-1:0];
            rx_count_d = rx_count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered status follows the next state so it lines up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      send_idx_q <= '0;
      timer_q    <= '0;
      in_valid_q <= 1'b0;
      sym_out_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      send_idx_q <= send_idx_d;
      timer_q    <= timer_d;
      in_valid_q <= in_valid_d;
      sym_out_q  <= sym_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign IN_VALID = in_valid_q;
  assign INPUT    = sym_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign overflow = overflow_q;
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_pattern_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lab3_pattern_master                                     |
// | Description : Self-checking bench for lab3_pattern_master. Acts as the   |
// |               host and as the LAB3 responder; expectations come from a   |
// |               queue-based model of frames and response bursts.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lab3_pattern_master;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int SYM_W   = 3;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              clear = 1'b0;
  logic              load_en = 1'b0;
  logic [SYM_W-1:0]  load_data = '0;
  logic              start = 1'b0;
  logic              IN_VALID;
  logic [SYM_W-1:0]  INPUT;
  logic              OUT_VALID = 1'b0;
  logic [SYM_W-1:0]  OUT = '0;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              overflow;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [SYM_W-1:0]  rd_data;

  int total = 0;
  int bad   = 0;

  logic [SYM_W-1:0] model_tx [$];
  logic [SYM_W-1:0] resp_q   [$];
  logic [SYM_W-1:0] got_q    [$];

  lab3_pattern_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYM_W(SYM_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .load_en   (load_en),
    .load_data (load_data),
    .start     (start),
    .IN_VALID  (IN_VALID),
    .INPUT     (INPUT),
    .OUT_VALID (OUT_VALID),
    .OUT       (OUT),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .overflow  (overflow),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_sym(input logic [SYM_W-1:0] s);
    load_en   = 1'b1;
    load_data = s;
    step();
    load_en   = 1'b0;
    if (model_tx.size() < DEPTH) model_tx.push_back(s);
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_tx.delete();
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) load_sym(SYM_W'($urandom_range(0, 7)));
  endtask

  task automatic random_resp(input int n);
    resp_q.delete();
    for (int i = 0; i < n; i++) resp_q.push_back(SYM_W'($urandom_range(0, 7)));
  endtask

  // One full transaction: start, collect the frame, answer with resp_q after
  // 'gap' idle cycles (empty resp_q = no answer), then check the outcome.
  task automatic run_frame(input string tag, input int gap, input bit poke);
    int  cnt;
    int  n_exp;
    bit  exp_to;
    exp_to = (resp_q.size() == 0) || (gap >= TIMEOUT);
    n_exp  = exp_to ? 0 : ((resp_q.size() > DEPTH) ? DEPTH : resp_q.size());

    start = 1'b1;
    step();
    start = 1'b0;
    got_q.delete();
    cnt = 0;
    while (IN_VALID === 1'b1 && cnt < 2 * DEPTH + 2) begin
      got_q.push_back(INPUT);
      // Host controls during SEND must have no effect.
      if (poke && cnt == 1) begin
        load_en = 1'b1; load_data = 3'd6; start = 1'b1; clear = 1'b1;
      end
      cnt++;
      step();
      load_en = 1'b0; start = 1'b0; clear = 1'b0;
    end
    check({tag, "_frame_len"}, got_q.size(), model_tx.size());
    for (int i = 0; i < model_tx.size() && i < got_q.size(); i++)
      check({tag, "_frame_sym"}, got_q[i], model_tx[i]);
    check({tag, "_input_zero"}, INPUT, 0);
    check({tag, "_tx_count"}, tx_count, model_tx.size());

    if (!exp_to) begin
      for (int i = 0; i < gap; i++) step();
      foreach (resp_q[i]) begin
        OUT_VALID = 1'b1;
        OUT       = resp_q[i];
        step();
      end
      OUT_VALID = 1'b0;
      OUT       = '0;
    end

    cnt = 0;
    while (done !== 1'b1 && cnt < TIMEOUT + 2 * DEPTH + 10) begin
      step();
      cnt++;
    end
    check({tag, "_done_delay"}, cnt, exp_to ? TIMEOUT : 1);
    check({tag, "_timeout"}, timeout, exp_to);
    check({tag, "_overflow"}, overflow, !exp_to && (resp_q.size() > DEPTH));
    check({tag, "_rx_count"}, rx_count, n_exp);
    check({tag, "_in_valid_quiet"}, IN_VALID, 0);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    for (int i = 0; i < n_exp; i++) begin
      rd_addr = ADDR_W'(i);
      #1;
      check({tag, "_rd_data"}, rd_data, resp_q[i]);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_in_valid", IN_VALID, 0);
    check("rst_input", INPUT, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    RST = 1'b1;
    step();

    // Start with nothing loaded is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("empty_start_busy", busy, 0);
    check("empty_start_in_valid", IN_VALID, 0);

    // Basic frame
    load_sym(3'd3);
    load_sym(3'd5);
    load_sym(3'd7);
    resp_q.delete();
    resp_q.push_back(3'd1);
    resp_q.push_back(3'd2);
    run_frame("basic", 1, 1'b0);

    // Replays of the same frame with host pokes during SEND
    for (int k = 0; k < 3; k++) begin
      random_resp($urandom_range(1, 6));
      run_frame("replay", $urandom_range(0, TIMEOUT - 2), 1'b1);
    end

    // Timeout with a single-symbol frame
    clear_buf();
    check("clear_tx_count", tx_count, 0);
    load_random(1);
    resp_q.delete();
    run_frame("timeout", 0, 1'b0);

    // Response lands on the expiry cycle: capture wins
    random_resp(1);
    run_frame("simul", TIMEOUT - 1, 1'b0);

    // Saturation of TX and overflow of RX
    clear_buf();
    load_random(DEPTH + 1);
    check("tx_saturate", tx_count, DEPTH);
    random_resp(DEPTH + 2);
    run_frame("overflow", 0, 1'b0);

    // Reset during SEND, then normal operation
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("midrst_sending", IN_VALID, 1);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_in_valid", IN_VALID, 0);
    check("midrst_tx_count", tx_count, 0);
    check("midrst_busy", busy, 0);
    model_tx.delete();
    @(negedge CLK);
    RST = 1'b1;
    step();
    load_random(2);
    random_resp(3);
    run_frame("post_rst", 2, 1'b0);

    // Random frames, including some that never get an answer
    for (int k = 0; k < 6; k++) begin
      clear_buf();
      load_random($urandom_range(1, DEPTH));
      random_resp($urandom_range(0, DEPTH + 3));
      run_frame("rand", $urandom_range(0, TIMEOUT - 1), k[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lab3_pattern_master.md
Name: lab3_pattern_master

Overview:
Synthesizable on-chip stimulus/response engine for the LAB3 symbol stream. It plays the driving side of the IN_VALID/INPUT interface and the collecting side of the OUT_VALID/OUT interface, i.e. the hardware counterpart of the bench pattern driver. It replays a host-loaded frame of 3-bit symbols into LAB3, then captures the LAB3 response burst into a readable buffer. Status flags report timeout and overflow.

Parameters:
DEPTH, 16, max symbols in TX frame and RX capture buffer (power of 2)
TIMEOUT, 1000, max cycles in WAIT before giving up (>=1)
SYM_W, 3, symbol width; must equal the LAB3 INPUT/OUT width

Ports:
CLK  in  1  sole clock, rising edge
RST  in  1  reset; asynchronous, active-low
clear  in  1  IDLE only: empties TX buffer (tx_count<=0)
load_en  in  1  IDLE only: append load_data to TX buffer
load_data  in  SYM_W  symbol to append
start  in  1  IDLE only: launch frame
IN_VALID  out  1  to LAB3: symbol valid
INPUT  out  SYM_W  to LAB3: symbol
OUT_VALID  in  1  from LAB3: response valid
OUT  in  SYM_W  from LAB3: response symbol
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of transaction
timeout  out  1  sticky; set on WAIT expiry; cleared by next accepted start
overflow  out  1  sticky; response exceeded DEPTH; cleared by next accepted start
tx_count  out  clog2(DEPTH)+1  symbols loaded
rx_count  out  clog2(DEPTH)+1  symbols captured
rd_addr  in  clog2(DEPTH)  RX buffer read address
rd_data  out  SYM_W  RX buffer content at rd_addr, combinational read

Behaviour:
- Reset (RST=0, async): state IDLE; IN_VALID, INPUT, busy, done, timeout, overflow, tx_count, rx_count all 0. Buffer contents undefined.
- All outputs except rd_data are registered.
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE:
  - clear has priority over load_en, which has priority over start.
  - load_en with tx_count<DEPTH writes tx_mem[tx_count] and increments tx_count. At tx_count==DEPTH, load_en is ignored.
  - start with tx_count==0 is ignored.
  - start with tx_count>0: clears rx_count, timeout, overflow and the timer; goes to SEND.
- SEND:
  - If start is sampled at edge t, IN_VALID=1 from edge t+1 for exactly tx_count consecutive cycles.
  - INPUT=tx_mem[0..tx_count-1] in order, no gaps.
  - The edge that ends the last symbol drives IN_VALID=0, INPUT=0 and enters WAIT.
  - OUT_VALID during SEND is ignored.
- WAIT:
  - Timer increments each cycle.
  - OUT_VALID=1: capture OUT into rx_mem[0], rx_count=1, go to RECV.
  - Timer==TIMEOUT-1 without OUT_VALID: timeout=1, go to DONE.
  - OUT_VALID wins over expiry in the same cycle.
- RECV:
  - Each cycle with OUT_VALID=1: if rx_count<DEPTH, write rx_mem[rx_count] and increment rx_count; else drop the symbol and set overflow.
  - OUT_VALID=0 goes to DONE; the burst is assumed contiguous.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- TX buffer is retained after a transaction, so start can replay the same frame.
- load_en, clear and start outside IDLE are ignored (no queuing).
- Reset mid-transaction aborts immediately: IN_VALID drops asynchronously, tx_count returns to 0.
- Counters never wrap: tx_count and rx_count saturate at DEPTH.

Decomposition:
- Package lab3_pkg holds:
  - SYM_W default 3
  - the state enum (IDLE, SEND, WAIT, RECV, DONE)
  - a DEPTH-derived address-width localparam
- Sub-module lab3_sym_buf: DEPTH x SYM_W memory with synchronous write and asynchronous read; no reset on contents.
  - Instance 1 is the TX buffer, read by the SEND index.
  - Instance 2 is the RX buffer, read by rd_addr.
- The FSM, timer, counters and flags live in lab3_pattern_master.

Test Plan:
- Basic frame: load 3,5,7; pulse start at cycle 0 → IN_VALID=1 on cycles 1–3 with INPUT=3,5,7. Model replies OUT=1,2 on OUT_VALID 2 cycles later → rx_count=2, rd_data[0]=1, rd_data[1]=2, done pulses once, timeout=0.
- Timeout: TIMEOUT=8, load 1 symbol, model never asserts OUT_VALID → timeout=1 and done exactly 8 cycles after IN_VALID falls; rx_count=0.
- Overflow and saturation:
  - load 17 symbols with DEPTH=16 → tx_count=16, 17th ignored.
  - model returns 18 symbols → rx_count=16, overflow=1.
- Ignored controls: start with empty buffer → busy stays 0. load_en/start during SEND → tx_count unchanged, no second frame. Replay with no reload → identical INPUT sequence.
- Reset mid-SEND: assert RST at the 2nd symbol → IN_VALID=0 immediately, tx_count=0, state IDLE; a new load + start works normally.
- Simultaneous events: OUT_VALID arrives on the same cycle as timer expiry → capture wins, timeout=0.
